// File: rtl/fetch_pkg.sv
// Shared fetch types: the pc/npc/instruction entry handed from fetch to decode.
// Entry widths follow the default 32-bit PC; wider cores retype the buffer locally.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    npc;
    logic [INSTR_W-1:0] ir;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// Fetch port bundle: imem request/response, execute redirect and the decode-side output.
// master = fetch unit side, slave = memory/execute/decode side.
interface fetch_if #(parameter int XLEN = 32);
  logic                         imem_req;
  logic [XLEN-1:0]              imem_addr;
  logic                         imem_ready;
  logic                         imem_rvalid;
  logic [fetch_pkg::INSTR_W-1:0] imem_rdata;
  logic                         redirect_valid;
  logic [XLEN-1:0]              redirect_pc;
  logic                         out_valid;
  logic                         out_ready;
  logic [XLEN-1:0]              out_pc;
  logic [XLEN-1:0]              out_npc;
  logic [fetch_pkg::INSTR_W-1:0] out_ir;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_npc, out_ir,
    input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_npc, out_ir,
    output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and wrap-around pointers; head is registered storage.
// Push lands one cycle later; push+pop together is legal, the caller guarantees no overflow.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  T              push_dat_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output T              head_o,
  output logic [CW-1:0] count_o
);
  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Decoupled fetch: PC, in-order imem requests, DEPTH-entry buffer; response to out_valid is 1 cycle.
// Issue stalls when buffered + in-flight reaches DEPTH; FETCH_PERF_CNT_EN adds perf counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_flushed
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    npc;
    logic [INSTR_W-1:0] ir;
  } entry_t;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   stale_q, stale_d;
  logic [CW-1:0]   occ;
  logic [CW-1:0]   inflight;
  logic            accept, resp, live_resp, drop_resp, pop;
  logic [XLEN-1:0] req_pc;
  entry_t          push_ent;
  entry_t          head;
  logic [1:0]      unused_pc_lsb;

  assign unused_pc_lsb = bus.redirect_pc[1:0];

  // Credit: every accepted request already owns a buffer slot.
  assign bus.imem_req  = !rst && !bus.redirect_valid &&
                         (({1'b0, occ} + {1'b0, inflight}) < (CW+1)'(DEPTH));
  assign bus.imem_addr = pc_q;
  assign accept        = bus.imem_req && bus.imem_ready;
  assign resp          = bus.imem_rvalid && !rst;
  assign drop_resp     = resp && (stale_q != '0);
  assign live_resp     = resp && (stale_q == '0);
  assign bus.out_valid = (occ != '0) && !bus.redirect_valid;
  assign pop           = bus.out_valid && bus.out_ready;

  // Addresses of live requests; its count is the in-flight counter.
  fetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_addr_q (
    .clk, .rst,
    .push_i(accept), .push_dat_i(pc_q), .pop_i(live_resp), .flush_i(bus.redirect_valid),
    .head_o(req_pc), .count_o(inflight)
  );

  always_comb begin
    push_ent     = '0;
    push_ent.pc  = req_pc;
    push_ent.npc = req_pc + XLEN'(PC_STEP);
    push_ent.ir  = bus.imem_rdata;
  end

  fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_buf (
    .clk, .rst,
    .push_i(live_resp && !bus.redirect_valid), .push_dat_i(push_ent), .pop_i(pop),
    .flush_i(bus.redirect_valid), .head_o(head), .count_o(occ)
  );

  assign bus.out_pc  = head.pc;
  assign bus.out_npc = head.npc;
  assign bus.out_ir  = head.ir;

  always_comb begin
    pc_d    = pc_q;
    stale_d = stale_q;
    if (bus.redirect_valid) begin
      pc_d    = {bus.redirect_pc[XLEN-1:2], 2'b00};
      stale_d = stale_q + inflight - CW'(resp);
    end else begin
      if (accept)    pc_d    = pc_q + XLEN'(PC_STEP);
      if (drop_resp) stale_d = stale_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      stale_q <= '0;
    end else begin
      pc_q    <= pc_d;
      stale_q <= stale_d;
    end
  end

  a_resp_owed: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rvalid |-> (inflight != '0 || stale_q != '0));

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, bubbles_q, flushed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      bubbles_q <= '0;
      flushed_q <= '0;
    end else begin
      if (pop) fetched_q <= fetched_q + 32'd1;
      if (bus.out_ready && !bus.out_valid) bubbles_q <= bubbles_q + 32'd1;
      flushed_q <= flushed_q + (bus.redirect_valid ? 32'(occ) : 32'd0) + 32'(drop_resp);
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
  assign perf_flushed = flushed_q;
`endif
endmodule
